mem_responder: RTL and testbench

//  Memory-side responder for the datapath's MAR/MDR memory interface.

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the MAR/MDR interface: accepts level read/write
// requests, inserts WAIT_CYCLES wait states, then strobes done for one cycle.
//
// state | meaning
// IDLE  | ready for a request or a preload
// WAIT  | counting wait states; address/data/op are the latched copies
// RESP  | done=1 for one cycle; read data valid, a write commits on exit
// HOLD  | waiting for the requester to drop read/write
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              done,
  output logic              busy,
  output logic              err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                op_wr_q;
  logic                accept, conflict, rd_load;
  logic [ADDR_W-1:0]   rd_addr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    conflict  = 1'b0;
    rd_load   = 1'b0;
    rd_addr   = addr_q;
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    case (state)
      IDLE: begin
        if (read ^ write) begin
          accept  = 1'b1;
          cnt_nxt = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_nxt = RESP;
            rd_load   = read;
            rd_addr   = address;
          end else begin
            state_nxt = WAIT;
          end
        end else if (read && write) begin
          conflict = 1'b1;
        end else if (ld_en) begin
          mem_we = 1'b1;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          rd_load   = ~op_wr_q;
        end
      end
      RESP: begin
        state_nxt = HOLD;
        if (op_wr_q) begin
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = wdata_q;
        end
      end
      HOLD: begin
        if (!read && !write) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      Mdatain <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= conflict;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= wdata;
        op_wr_q <= write;
      end
      if (rd_load) Mdatain <= mem[rd_addr];
    end
  end

  // RAM has no reset; an abort drops state to IDLE so a pending RESP write never fires.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign done = (state == RESP);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (0, 1 and 4 wait states) share one stimulus
// stream and are compared against a transaction-level memory model.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        clear;
  logic [8:0]  address;
  logic        read, write;
  logic [31:0] wdata;
  logic        ld_en;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0] md   [3];
  logic        done [3];
  logic        busy [3];
  logic        err  [3];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mmem [512];
  logic [31:0] mmd;

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] data;
    int          hold;
    bit          chg;
    logic [31:0] exp_md;
  } vec_t;

  vec_t tbl [8];

  always #5 clock = ~clock;

  mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .clear(clear), .address(address), .read(read), .write(write),
    .wdata(wdata), .Mdatain(md[0]), .done(done[0]), .busy(busy[0]), .err(err[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(1)) u_w1 (
    .clock(clock), .clear(clear), .address(address), .read(read), .write(write),
    .wdata(wdata), .Mdatain(md[1]), .done(done[1]), .busy(busy[1]), .err(err[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(4)) u_w4 (
    .clock(clock), .clear(clear), .address(address), .read(read), .write(write),
    .wdata(wdata), .Mdatain(md[2]), .done(done[2]), .busy(busy[2]), .err(err[2]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  function automatic int wcyc(int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 4;
  endfunction

  task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic preload(logic [8:0] a, logic [31:0] d);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
    mmem[a] = d;
  endtask

  // One complete request held for 'hold' edges; done timing, data and release checked.
  task automatic access(bit wr, logic [8:0] a, logic [31:0] d, int hold, bit chg);
    int          first  [3];
    int          pulses [3];
    logic [31:0] exp_md;
    exp_md = wr ? mmd : mmem[a];
    for (int i = 0; i < 3; i++) begin first[i] = -1; pulses[i] = 0; end
    @(negedge clock);
    address = a; wdata = d; read = ~wr; write = wr;
    @(posedge clock);
    for (int n = 0; n < hold; n++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          if (pulses[i] == 0) first[i] = n;
          pulses[i]++;
          check("data_at_done", i, md[i], exp_md);
        end
      end
      @(negedge clock);
      if (chg && n == 0) begin address = a + 9'd1; wdata = ~d; end
      if (n == hold - 1) begin read = 1'b0; write = 1'b0; end
      @(posedge clock);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check("done_latency", i, 32'(first[i]), 32'(wcyc(i)));
      check("done_pulses", i, 32'(pulses[i]), 32'd1);
      check("busy_after_release", i, 32'(busy[i]), 32'd0);
      check("mdatain_after", i, md[i], exp_md);
    end
    if (wr) mmem[a] = d;
    mmd = exp_md;
  endtask

  task automatic conflict(logic [8:0] a);
    @(negedge clock);
    address = a; wdata = $urandom; read = 1'b1; write = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("err_pulse", i, 32'(err[i]), 32'd1);
      check("err_no_done", i, 32'(done[i]), 32'd0);
      check("err_no_busy", i, 32'(busy[i]), 32'd0);
    end
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("err_cleared", i, 32'(err[i]), 32'd0);
      check("err_mdatain", i, md[i], mmd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b0; address = '0; read = 1'b0; write = 1'b0; wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    mmd = '0;
    #23;
    clear = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_mdatain", i, md[i], 32'd0);
      check("reset_done", i, 32'(done[i]), 32'd0);
      check("reset_busy", i, 32'(busy[i]), 32'd0);
      check("reset_err", i, 32'(err[i]), 32'd0);
    end

    for (int a = 0; a < 512; a++) preload(9'(a), $urandom);
    preload(9'h000, 32'h3A880009);
    preload(9'h005, 32'h11112222);
    preload(9'h1FF, 32'h0BADF00D);

    tbl[0] = '{1'b0, 9'h000, 32'h0,        6,  1'b0, 32'h3A880009};
    tbl[1] = '{1'b1, 9'h1F0, 32'hDEADBEEF, 6,  1'b0, 32'h3A880009};
    tbl[2] = '{1'b0, 9'h1F0, 32'h0,        6,  1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 9'h005, 32'h0,        10, 1'b0, 32'h11112222};
    tbl[4] = '{1'b0, 9'h000, 32'h0,        7,  1'b1, 32'h3A880009};
    tbl[5] = '{1'b1, 9'h1FF, 32'h12345678, 6,  1'b1, 32'h3A880009};
    tbl[6] = '{1'b0, 9'h1FF, 32'h0,        6,  1'b0, 32'h12345678};
    tbl[7] = '{1'b0, 9'h000, 32'h0,        6,  1'b0, 32'h3A880009};
    for (int v = 0; v < 8; v++) begin
      access(tbl[v].wr, tbl[v].addr, tbl[v].data, tbl[v].hold, tbl[v].chg);
      for (int i = 0; i < 3; i++) check($sformatf("vec%0d_mdatain", v), i, md[i], tbl[v].exp_md);
    end

    conflict(9'h005);
    access(1'b0, 9'h005, 32'h0, 6, 1'b0);
    for (int i = 0; i < 3; i++) check("conflict_mem_intact", i, md[i], 32'h11112222);

    // Abort mid-wait: read accepted, then reset before completion
    @(negedge clock);
    address = 9'h1F0; read = 1'b1;
    @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("abort_mdatain", i, md[i], 32'd0);
      check("abort_done", i, 32'(done[i]), 32'd0);
      check("abort_busy", i, 32'(busy[i]), 32'd0);
    end
    mmd = '0;
    @(negedge clock);
    read = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    access(1'b0, 9'h1F0, 32'h0, 6, 1'b0);
    for (int i = 0; i < 3; i++) check("post_abort_read", i, md[i], 32'hDEADBEEF);

    for (int r = 0; r < 40; r++) begin
      int unsigned sel;
      logic [8:0]  a;
      logic [31:0] d;
      sel = $urandom_range(0, 9);
      a   = 9'($urandom) & 9'h10F;
      d   = $urandom;
      if (sel == 0)      conflict(a);
      else if (sel == 1) preload(a, d);
      else access(sel >= 6, a, d, int'($urandom_range(6, 9)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
